jtag_tap_seq: RTL and testbench

JTAG_TAP_SEQ -- requirements
Module: jtag_tap_seq

---
 rtl/jtag_tap_seq_if.sv | 11 +
 rtl/jtag_tap_seq.sv | 181 ++++++++++++++++++
 tb/tb_jtag_tap_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_seq_if.sv
// JTAG pin bundle between the TAP sequencer (master) and the target TAP.
interface jtagif;
  logic tck;
  logic tms;
  logic tdi;
  logic trst;
  logic tdo;

  modport master (output tck, output tms, output tdi, output trst, input tdo);
  modport slave  (input tck, input tms, input tdi, input trst, output tdo);
endinterface

// File: rtl/jtag_tap_seq.sv
// JTAG TAP command sequencer: turns TAPRESET/SHIFTIR/SHIFTDR/IDLE commands
// into TCK/TMS/TDI waveforms and collects TDO bits of shift cycles.
module jtag_tap_seq #(
  parameter int unsigned CLKDIV = 2,
  parameter int unsigned MAXLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [5:0]        cmd_len,
  input  logic [MAXLEN-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [MAXLEN-1:0] rsp_data,
  output logic              busy,
  jtagif.master             jtagm
);

  localparam int unsigned IW = $clog2(MAXLEN + 7);
  localparam int unsigned DW = $clog2(2 * CLKDIV);
  localparam logic [DW-1:0] DIV_HI   = DW'(CLKDIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLKDIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {
    CMD_TAPRESET = 2'd0,
    CMD_SHIFTIR  = 2'd1,
    CMD_SHIFTDR  = 2'd2,
    CMD_IDLE     = 2'd3
  } cmd_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  cmd_e              type_q, type_d;
  logic [IW-1:0]     len_q, len_d;
  logic [MAXLEN-1:0] data_q, data_d;
  logic [MAXLEN-1:0] rsp_q, rsp_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              trst_q, trst_d;

  logic [IW-1:0]     sh_q;
  logic [IW-1:0]     pre_d;
  logic [IW-1:0]     sh_d;
  logic [MAXLEN-1:0] data_sh;

  // Number of TCKs before the first shift TCK (Run-Test/Idle -> Shift-xR).
  function automatic logic [IW-1:0] pre_len(input cmd_e t);
    case (t)
      CMD_SHIFTIR: pre_len = IW'(4);
      CMD_SHIFTDR: pre_len = IW'(3);
      default:     pre_len = '0;
    endcase
  endfunction

  function automatic logic [IW-1:0] tck_count(input cmd_e t, input logic [IW-1:0] l);
    case (t)
      CMD_TAPRESET: tck_count = IW'(6);
      CMD_SHIFTIR:  tck_count = l + IW'(6);
      CMD_SHIFTDR:  tck_count = l + IW'(5);
      default:      tck_count = l;
    endcase
  endfunction

  function automatic logic in_shift(input cmd_e t, input logic [IW-1:0] l,
                                    input logic [IW-1:0] k);
    in_shift = (t == CMD_SHIFTIR || t == CMD_SHIFTDR) &&
               (k >= pre_len(t)) && (k < pre_len(t) + l);
  endfunction

  // Next-state: command latch, TCK phase/index counters, TDO capture.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    type_d  = type_q;
    len_d   = len_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    sh_q    = idx_q - pre_len(type_q);
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = RUN;
          div_d   = '0;
          idx_d   = '0;
          type_d  = cmd_e'(cmd_type);
          len_d   = (cmd_len == '0) ? IW'(MAXLEN) : IW'(cmd_len);
          data_d  = cmd_data;
          rsp_d   = '0;
        end
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (idx_q == tck_count(type_q, len_q) - IW'(1)) state_d = DONE;
          else                                            idx_d   = idx_q + IW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
        // tdo is taken in the cycle where tck is first high
        if (div_q == DIV_HI && in_shift(type_q, len_q, idx_q))
          rsp_d = rsp_q | ({{(MAXLEN-1){1'b0}}, jtagm.tdo} << sh_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from next state so the pins are plain flops.
  always_comb begin
    tck_d   = 1'b0;
    tms_d   = 1'b1;
    tdi_d   = 1'b0;
    trst_d  = 1'b1;
    pre_d   = pre_len(type_d);
    sh_d    = idx_d - pre_d;
    data_sh = data_d >> sh_d;
    if (state_d == RUN) begin
      tck_d = (div_d >= DIV_HI);
      unique case (type_d)
        CMD_TAPRESET: begin
          tms_d  = (idx_d < IW'(5));
          trst_d = !(idx_d < IW'(5));
        end
        CMD_IDLE: tms_d = 1'b0;
        default: begin
          if (idx_d < pre_d) begin
            tms_d = (idx_d < pre_d - IW'(2));
          end else if (idx_d < pre_d + len_d) begin
            tms_d = (sh_d == len_d - IW'(1));
            tdi_d = data_sh[0];
          end else begin
            tms_d = (idx_d == pre_d + len_d);
          end
        end
      endcase
    end
  end

  // State and pin registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      type_q  <= CMD_TAPRESET;
      len_q   <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      trst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      type_q  <= type_d;
      len_q   <= len_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      trst_q  <= trst_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE) && !reset;
  assign rsp_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign rsp_data   = rsp_q;
  assign jtagm.tck  = tck_q;
  assign jtagm.tms  = tms_q;
  assign jtagm.tdi  = tdi_q;
  assign jtagm.trst = trst_q;

endmodule

// File: tb/tb_jtag_tap_seq.sv
// Self-checking bench for jtag_tap_seq: directed vector table, random
// commands against a sequence-level model, and reset/back-to-back cases.
module tb_jtag_tap_seq;
  localparam int CD = 4;   // TCK period of 8 clk cycles
  localparam int ML = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  int          tdo_mode;   // 0 loopback, 1 tied 1, 2 tied 0, 3 inverted loopback

  jtagif jif();
  assign jif.tdo = (tdo_mode == 0) ? jif.tdi :
                   (tdo_mode == 1) ? 1'b1 :
                   (tdo_mode == 2) ? 1'b0 : ~jif.tdi;

  jtag_tap_seq #(.CLKDIV(CD), .MAXLEN(ML)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .jtagm     (jif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: per-TCK pin sequences built from the command rules.
  bit exp_tms[$];
  bit exp_tdi[$];
  bit exp_trst[$];

  task automatic push_tck(input bit tms, input bit tdi, input bit trst);
    exp_tms.push_back(tms);
    exp_tdi.push_back(tdi);
    exp_trst.push_back(trst);
  endtask

  task automatic build_model(input int t, input int L, input logic [31:0] d);
    int ones;
    exp_tms.delete();
    exp_tdi.delete();
    exp_trst.delete();
    case (t)
      0: for (int i = 0; i < 6; i++) push_tck(i < 5, 1'b0, i >= 5);
      1, 2: begin
        ones = (t == 1) ? 2 : 1;
        for (int i = 0; i < ones + 2; i++) push_tck(i < ones, 1'b0, 1'b1);
        for (int k = 0; k < L; k++) push_tck(k == L - 1, d[k], 1'b1);
        push_tck(1'b1, 1'b0, 1'b1);
        push_tck(1'b0, 1'b0, 1'b1);
      end
      default: for (int i = 0; i < L; i++) push_tck(1'b0, 1'b0, 1'b1);
    endcase
  endtask

  function automatic logic [31:0] model_rsp(input int t, input int L, input logic [31:0] d,
                                            input int mode);
    logic [63:0] mask;
    logic [31:0] m;
    mask = (64'd1 << L) - 64'd1;
    m    = mask[31:0];
    if (t == 0 || t == 3) return 32'h0;
    case (mode)
      0:       return d & m;
      1:       return m;
      2:       return 32'h0;
      default: return ~d & m;
    endcase
  endfunction

  // Issue one command and check its full waveform, latency and response.
  task automatic run_cmd(input string tag, input int t, input int len_field,
                         input logic [31:0] d, input int mode,
                         input logic [31:0] exp_rsp, input int exp_lat);
    int L, n, w, c, rises;
    bit prev_tck, prev_tms, prev_tdi;
    bit timing_ok, change_ok, busy_ok, done;
    logic [63:0] g_tms, g_tdi, g_trst, e_tms, e_tdi, e_trst;
    logic [31:0] got_rsp;
    L = (len_field == 0) ? ML : len_field;
    build_model(t, L, d);
    n = exp_tms.size();
    tdo_mode  = mode;
    cmd_type  = t[1:0];
    cmd_len   = len_field[5:0];
    cmd_data  = d;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "/ready"}, cmd_ready, 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    prev_tck = jif.tck; prev_tms = jif.tms; prev_tdi = jif.tdi;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c = 1; rises = 0; done = 0;
    timing_ok = 1; change_ok = 1; busy_ok = 1;
    g_tms = '0; g_tdi = '0; g_trst = '0; got_rsp = '0;
    while (c <= 2 * CD * 40 + 4) begin
      if (rsp_valid) begin
        done = 1;
        got_rsp = rsp_data;
        break;
      end
      if (!busy) busy_ok = 0;
      if (jif.tck && !prev_tck) begin
        if (rises < 64) begin
          g_tms[rises]  = jif.tms;
          g_tdi[rises]  = jif.tdi;
          g_trst[rises] = jif.trst;
        end
        if (c != CD + 1 + 2 * CD * rises) timing_ok = 0;
        rises++;
      end
      if ((jif.tms !== prev_tms || jif.tdi !== prev_tdi) && !(c == 1 || (prev_tck && !jif.tck)))
        change_ok = 0;
      prev_tck = jif.tck; prev_tms = jif.tms; prev_tdi = jif.tdi;
      @(posedge clk); #1;
      c++;
    end
    e_tms = '0; e_tdi = '0; e_trst = '0;
    for (int i = 0; i < n; i++) begin
      e_tms[i]  = exp_tms[i];
      e_tdi[i]  = exp_tdi[i];
      e_trst[i] = exp_trst[i];
    end
    chk({tag, "/latency"}, done ? c : -1, exp_lat);
    chk({tag, "/tck_count"}, rises, n);
    chk({tag, "/tms_seq"}, g_tms, e_tms);
    chk({tag, "/tdi_seq"}, g_tdi, e_tdi);
    chk({tag, "/trst_seq"}, g_trst, e_trst);
    chk({tag, "/tck_timing"}, timing_ok, 1);
    chk({tag, "/pin_change_low_phase"}, change_ok, 1);
    chk({tag, "/busy_in_run"}, busy_ok, 1);
    chk({tag, "/rsp_data"}, got_rsp, exp_rsp);
    @(posedge clk); #1;
    chk({tag, "/rsp_pulse_one_cycle"}, rsp_valid, 0);
    chk({tag, "/rsp_hold"}, rsp_data, exp_rsp);
    chk({tag, "/idle_after"}, {busy, cmd_ready, jif.tck}, 3'b010);
  endtask

  typedef struct {
    int          t;
    int          len;
    logic [31:0] data;
    int          mode;
    logic [31:0] rsp;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int c, r1, acc2, r2, busy_low, w;
    logic [31:0] rd2;
    int t, len, mode, L;
    logic [31:0] d;

    vecs[0] = '{t: 0, len: 1,  data: 32'h0,        mode: 0, rsp: 32'h0,        lat: 49};
    vecs[1] = '{t: 2, len: 8,  data: 32'hA5,       mode: 0, rsp: 32'hA5,       lat: 105};
    vecs[2] = '{t: 1, len: 5,  data: 32'h11,       mode: 1, rsp: 32'h1F,       lat: 89};
    vecs[3] = '{t: 2, len: 0,  data: 32'hDEADBEEF, mode: 0, rsp: 32'hDEADBEEF, lat: 297};
    vecs[4] = '{t: 3, len: 3,  data: 32'hFFFFFFFF, mode: 1, rsp: 32'h0,        lat: 25};
    vecs[5] = '{t: 1, len: 32, data: 32'h0F0F0F0F, mode: 3, rsp: 32'hF0F0F0F0, lat: 305};
    vecs[6] = '{t: 2, len: 1,  data: 32'h1,        mode: 0, rsp: 32'h1,        lat: 49};
    vecs[7] = '{t: 2, len: 7,  data: 32'hFF,       mode: 0, rsp: 32'h7F,       lat: 97};
    vecs[8] = '{t: 3, len: 0,  data: 32'h0,        mode: 0, rsp: 32'h0,        lat: 257};

    reset = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_len = '0; cmd_data = '0; tdo_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/pins", {jif.tck, jif.tms, jif.tdi, jif.trst}, 4'b0101);
    chk("reset/outputs", {cmd_ready, rsp_valid, busy}, 3'b000);
    chk("reset/rsp_data", rsp_data, 0);
    reset = 1'b0;
    #1;
    chk("reset/ready_after_release", cmd_ready, 1);

    for (int i = 0; i < 9; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].t, vecs[i].len, vecs[i].data, vecs[i].mode,
              vecs[i].rsp, vecs[i].lat);

    // Reset in the middle of a SHIFTDR
    tdo_mode = 0; cmd_type = 2'd2; cmd_len = 6'd16; cmd_data = 32'h1234ABCD; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midreset/busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset/pins", {jif.tck, jif.tms, jif.tdi, jif.trst}, 4'b0101);
    chk("midreset/outputs", {cmd_ready, rsp_valid, busy}, 3'b000);
    reset = 1'b0;
    #1;
    chk("midreset/ready_after", cmd_ready, 1);
    run_cmd("after_reset", 2, 4, 32'h9, 0, 32'h9, 73);

    // Back-to-back: IDLE len 3 then SHIFTDR len 4 with cmd_valid held high
    tdo_mode = 0; cmd_type = 2'd3; cmd_len = 6'd3; cmd_data = 32'h0; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    cmd_type = 2'd2; cmd_len = 6'd4; cmd_data = 32'h6;
    c = 1; r1 = -1; acc2 = -1; r2 = -1; busy_low = 0; rd2 = '0;
    while (c < 300 && r2 < 0) begin
      if (!busy) busy_low++;
      if (rsp_valid && r1 < 0) r1 = c;
      else if (rsp_valid) begin
        r2 = c;
        rd2 = rsp_data;
      end
      if (r1 >= 0 && acc2 < 0 && cmd_ready) acc2 = c;
      @(posedge clk); #1;
      if (acc2 >= 0) cmd_valid = 1'b0;
      c++;
    end
    cmd_valid = 1'b0;
    chk("b2b/first_latency", r1, 25);
    chk("b2b/second_accept", acc2, r1 + 1);
    chk("b2b/busy_gap", busy_low, 1);
    chk("b2b/second_latency", (r2 >= 0) ? r2 - acc2 : -1, 73);
    chk("b2b/second_rsp", rd2, 32'h6);
    @(posedge clk); #1;

    // Random commands against the model
    for (int i = 0; i < 20; i++) begin
      t    = $urandom_range(0, 3);
      len  = $urandom_range(0, 32);
      d    = $urandom;
      mode = $urandom_range(0, 3);
      L    = (len == 0) ? ML : len;
      build_model(t, L, d);
      run_cmd($sformatf("rnd%0d", i), t, len, d, mode, model_rsp(t, L, d, mode),
              2 * CD * exp_tms.size() + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
